// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the per-instruction hazard decode helper
// used by the pipeline hazard/stall scheduler (hazard_ctrl).
package mips_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // Tuse: stages until a source is needed; NONE (3) exceeds any Tnew, so it never stalls
    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew as seen from the E stage
    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic [4:0] rs;
        logic [1:0] tuse_rs;
        logic [4:0] rt;
        logic [1:0] tuse_rt;
        logic [4:0] dest;       // 0 means no register write
        logic [1:0] tnew;       // Tnew when the instruction sits in E
        logic       start_mult; // mult/multu
        logic       start_div;  // div/divu
        logic       md_use;     // touches the mult/div unit or HI/LO
    } dec_t;

    // Decode one instruction word into its register usage and timing
    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        d            = '0;
        d.rs         = ir[25:21];
        d.rt         = ir[20:16];
        d.tuse_rs    = TUSE_NONE;
        d.tuse_rt    = TUSE_NONE;
        d.dest       = REG_ZERO;
        d.tnew       = TNEW_0;
        case (ir[31:26])
            OP_RTYPE: begin
                case (ir[5:0])
                    FN_ADDU, FN_SUBU: begin
                        d.tuse_rs = TUSE_1;
                        d.tuse_rt = TUSE_1;
                        d.dest    = ir[15:11];
                        d.tnew    = TNEW_1;
                    end
                    FN_JR: d.tuse_rs = TUSE_0;
                    FN_MULT, FN_MULTU: begin
                        d.tuse_rs    = TUSE_1;
                        d.tuse_rt    = TUSE_1;
                        d.start_mult = 1'b1;
                        d.md_use     = 1'b1;
                    end
                    FN_DIV, FN_DIVU: begin
                        d.tuse_rs   = TUSE_1;
                        d.tuse_rt   = TUSE_1;
                        d.start_div = 1'b1;
                        d.md_use    = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        d.dest   = ir[15:11];
                        d.tnew   = TNEW_1;
                        d.md_use = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        d.tuse_rs = TUSE_1;
                        d.md_use  = 1'b1;
                    end
                    default: d.md_use = 1'b0;
                endcase
            end
            OP_ORI: begin
                d.tuse_rs = TUSE_1;
                d.dest    = ir[20:16];
                d.tnew    = TNEW_1;
            end
            OP_LUI: begin
                d.dest = ir[20:16];
                d.tnew = TNEW_1;
            end
            OP_LW: begin
                d.tuse_rs = TUSE_1;
                d.dest    = ir[20:16];
                d.tnew    = TNEW_2;
            end
            OP_SW: begin
                d.tuse_rs = TUSE_1;
                d.tuse_rt = TUSE_2;
            end
            OP_BEQ: begin
                d.tuse_rs = TUSE_0;
                d.tuse_rt = TUSE_0;
            end
            OP_JAL: begin
                d.dest = REG_RA;
                d.tnew = TNEW_0;
            end
            default: d.dest = REG_ZERO;
        endcase
        return d;
    endfunction

    // Tnew one stage later (M): one cycle closer, floored at zero
    function automatic logic [1:0] tnew_at_mem(input logic [1:0] tnew_e);
        return (tnew_e == TNEW_0) ? TNEW_0 : (tnew_e - 2'd1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Busy down-counter for the multi-cycle mult/div unit. Loaded when a
// mult/div leaves E, then counts down to zero; busy is registered.
module md_busy_counter
    import mips_pkg::*;
#(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic Clock,
    input  logic Reset,
    input  logic start_mult,
    input  logic start_div,
    output logic busy
);

    localparam logic [3:0] MULT_LOAD_C = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD_C  = 4'(DIV_CYC);

    logic [3:0] cnt_r;
    logic [3:0] cnt_next_s;
    logic       busy_r;

    // Next count: a new operation reloads (even if still busy), otherwise count down
    always_comb begin
        cnt_next_s = cnt_r;
        if (start_mult) begin
            cnt_next_s = MULT_LOAD_C;
        end else if (start_div) begin
            cnt_next_s = DIV_LOAD_C;
        end else if (cnt_r != 4'd0) begin
            cnt_next_s = cnt_r - 4'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter and busy flag registers; busy mirrors (cnt != 0) from a flop
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_r  <= 4'd0;
            busy_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            busy_r <= (cnt_next_s != 4'd0);
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall scheduler for the 5-stage MIPS core.
// Detects RAW hazards forwarding cannot cover and mult/div unit conflicts,
// and drives PC/IF-ID hold and the ID/EX bubble.
// Optional: define HAZARD_STAT_EN to enable the Stall_Count statistics counter.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] IR_M,
    output logic        Stall_F,
    output logic        Stall_D,
    output logic        Flush_E,
    output logic        MD_Busy,
    output logic [31:0] Stall_Count
);

    dec_t       dec_d_s;
    dec_t       dec_e_s;
    dec_t       dec_m_s;
    logic [1:0] tnew_m_s;
    logic       raw_stall_s;
    logic       md_stall_s;
    logic       stall_s;
    logic       md_busy_s;
    logic       unused_s;

    // A source hazards when it is a real register, matches the producer, and the
    // producer's value arrives later than the consumer needs it
    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] dest, input logic [1:0] tnew);
        return (src != REG_ZERO) && (src == dest) && (tnew > tuse);
    endfunction

    assign dec_d_s  = decode(IR_D);
    assign dec_e_s  = decode(IR_E);
    assign dec_m_s  = decode(IR_M);
    assign tnew_m_s = tnew_at_mem(dec_m_s.tnew);

    // Stall decision: RAW against E and M producers, plus mult/div unit conflicts
    always_comb begin
        raw_stall_s = src_hazard(dec_d_s.rs, dec_d_s.tuse_rs, dec_e_s.dest, dec_e_s.tnew)
                    | src_hazard(dec_d_s.rt, dec_d_s.tuse_rt, dec_e_s.dest, dec_e_s.tnew)
                    | src_hazard(dec_d_s.rs, dec_d_s.tuse_rs, dec_m_s.dest, tnew_m_s)
                    | src_hazard(dec_d_s.rt, dec_d_s.tuse_rt, dec_m_s.dest, tnew_m_s);
        md_stall_s  = dec_d_s.md_use
                    & (md_busy_s | dec_e_s.start_mult | dec_e_s.start_div);
        stall_s     = raw_stall_s | md_stall_s;
    end

    md_busy_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_counter (
        .Clock      (Clock),
        .Reset      (Reset),
        .start_mult (dec_e_s.start_mult),
        .start_div  (dec_e_s.start_div),
        .busy       (md_busy_s)
    );

    assign Stall_F = stall_s;
    assign Stall_D = stall_s;
    assign Flush_E = stall_s;
    assign MD_Busy = md_busy_s;

`ifdef HAZARD_STAT_EN
    logic [31:0] stall_count_r;

    // Count every clock edge on which the pipeline is held; wraps naturally
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_count_r <= 32'h0;
        end else if (stall_s) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign Stall_Count = stall_count_r;
`else
    assign Stall_Count = 32'h0;
`endif

    // Decode fields that this block has no use for in a given stage
    assign unused_s = ^{dec_d_s.dest, dec_d_s.tnew, dec_d_s.start_mult, dec_d_s.start_div,
                        dec_e_s.rs, dec_e_s.rt, dec_e_s.tuse_rs, dec_e_s.tuse_rt, dec_e_s.md_use,
                        dec_m_s.rs, dec_m_s.rt, dec_m_s.tuse_rs, dec_m_s.tuse_rt,
                        dec_m_s.start_mult, dec_m_s.start_div, dec_m_s.md_use};

endmodule
